// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: serves hits from a tag buffer, fetches misses over a handshaked bus.
// Define INST_FETCH_CACHE_EN for a LINES-entry direct-mapped buffer; default is a single entry.
module inst_fetch_bridge #(
   parameter int LINES   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic [31:0] cpu_addr_i,
   input  logic        flush_i,
   output logic [31:0] cpu_inst_o,
   output logic        stallreq_o,
   output logic        err_o,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

`ifdef INST_FETCH_CACHE_EN
   localparam int NLINES = LINES;
`else
   localparam int NLINES = 1;
`endif
   localparam int IW = (NLINES > 1) ? $clog2(NLINES) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP_ERR} state_e;

   state_e            state_q, state_d;
   logic [NLINES-1:0] valid_q;
   logic [29:0]       tag_q  [NLINES];
   logic [31:0]       data_q [NLINES];
   logic [31:0]       busAddr_q;
   logic [CW-1:0]     cnt_q;
   logic              drop_q;

   logic [IW-1:0] cpuIdx;
   logic [IW-1:0] fillIdx;
   logic          hit;
   logic          respErrMatch;
   logic          fillEn;
   logic          timeoutHit;
   logic          unusedBits;

`ifdef INST_FETCH_CACHE_EN
   assign cpuIdx     = cpu_addr_i[IW+1:2];
   assign fillIdx    = busAddr_q[IW+1:2];
   assign unusedBits = ^cpu_addr_i[1:0];
`else
   assign cpuIdx     = '0;
   assign fillIdx    = '0;
   assign unusedBits = (^cpu_addr_i[1:0]) ^ (LINES == 0);
`endif

   assign hit          = cpu_ce_i && valid_q[cpuIdx] && (tag_q[cpuIdx] == cpu_addr_i[31:2]);
   assign respErrMatch = (state_q == RESP_ERR) && cpu_ce_i && (cpu_addr_i[31:2] == busAddr_q[31:2]);
   assign timeoutHit   = (cnt_q == CW'(TIMEOUT - 1));
   // A flush, either pending from earlier in the transaction or in this very cycle, blocks the fill
   assign fillEn       = (state_q == WAIT) && bus_rvalid_i && !drop_q && !flush_i;
   assign bus_addr_o   = busAddr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (cpu_ce_i && !hit) state_d = REQ;
         REQ:      if (bus_gnt_i) state_d = WAIT;
         WAIT: begin
            if (bus_rvalid_i) begin
               state_d = IDLE;
            end else if (timeoutHit) begin
               state_d = RESP_ERR;
            end
         end
         RESP_ERR: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_inst_o = '0;
      stallreq_o = 1'b0;
      err_o      = 1'b0;
      bus_req_o  = 1'b0;
      if (rst) begin
         err_o     = (state_q == RESP_ERR);
         bus_req_o = (state_q == REQ);
         if (respErrMatch) begin
            cpu_inst_o = '0;
         end else if (hit) begin
            cpu_inst_o = data_q[cpuIdx];
         end else if (cpu_ce_i) begin
            stallreq_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= '0;
         busAddr_q <= '0;
         cnt_q     <= '0;
         drop_q    <= 1'b0;
         for (int i = 0; i < NLINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if ((state_q == IDLE) && (state_d == REQ)) begin
            busAddr_q <= {cpu_addr_i[31:2], 2'b00};
            drop_q    <= 1'b0;
         end else if (flush_i && ((state_q == REQ) || (state_q == WAIT))) begin
            drop_q <= 1'b1;
         end
         if (state_q == REQ) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (fillEn) begin
            tag_q[fillIdx]  <= busAddr_q[31:2];
            data_q[fillIdx] <= bus_rdata_i;
         end
         if (flush_i) begin
            valid_q <= '0;
         end else if (fillEn) begin
            valid_q[fillIdx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: vector table plus hand-written timeout, flush
// and async-reset sequences; expected instructions go through a scoreboard queue.
module tb_inst_fetch_bridge;

   localparam int TO = 8;
`ifdef INST_FETCH_CACHE_EN
   localparam int NL = 4;
`else
   localparam int NL = 1;
`endif

   logic        clk;
   logic        rst;
   logic        cpuCe;
   logic [31:0] cpuAddr;
   logic        flush;
   logic [31:0] cpuInst;
   logic        stallreq;
   logic        err;
   logic        busReq;
   logic [31:0] busAddr;
   logic        busGnt;
   logic        busRvalid;
   logic [31:0] busRdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] expQ [$];

   // Reference buffer: which words are currently held and what they contain
   logic        mValid [4];
   logic [29:0] mTag   [4];
   logic [31:0] mData  [4];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      int          gntDly;
      int          rvDly;
   } vec_t;

   vec_t vecs [11];

   inst_fetch_bridge #(.LINES(4), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_ce_i     (cpuCe),
      .cpu_addr_i   (cpuAddr),
      .flush_i      (flush),
      .cpu_inst_o   (cpuInst),
      .stallreq_o   (stallreq),
      .err_o        (err),
      .bus_req_o    (busReq),
      .bus_addr_o   (busAddr),
      .bus_gnt_i    (busGnt),
      .bus_rvalid_i (busRvalid),
      .bus_rdata_i  (busRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int mIdx(logic [31:0] a);
      return (NL == 1) ? 0 : int'(a[3:2]);
   endfunction

   function automatic void mInvalidate();
      for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic popCompare(string name);
      logic [31:0] e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected nothing queued", name, cpuInst);
      end else begin
         e = expQ.pop_front();
         checkOutput(name, cpuInst, e);
      end
   endtask

   // Full miss transaction with the bench acting as bus slave
   task automatic doMiss(vec_t v);
      cpuCe   = 1'b1;
      cpuAddr = v.addr;
      @(negedge clk);
      checkOutput("miss_stall", 32'(stallreq), 32'd1);
      checkOutput("miss_idle_noreq", 32'(busReq), 32'd0);
      tick();
      for (int k = 0; k < v.gntDly; k++) begin
         @(negedge clk);
         checkOutput("req_held", 32'(busReq), 32'd1);
         tick();
      end
      busGnt = 1'b1;
      @(negedge clk);
      checkOutput("req_addr", busAddr, {v.addr[31:2], 2'b00});
      tick();
      busGnt = 1'b0;
      for (int k = 0; k < v.rvDly; k++) begin
         @(negedge clk);
         checkOutput("wait_noerr", {30'd0, err, stallreq}, 32'd1);
         tick();
      end
      busRvalid = 1'b1;
      busRdata  = v.inst;
      expQ.push_back(v.inst);
      @(negedge clk);
      checkOutput("rvalid_still_stalled", {30'd0, err, stallreq}, 32'd1);
      tick();
      busRvalid = 1'b0;
      busRdata  = '0;
      @(negedge clk);
      checkOutput("fill_stall_drop", 32'(stallreq), 32'd0);
      popCompare("fill_inst");
      mValid[mIdx(v.addr)] = 1'b1;
      mTag[mIdx(v.addr)]   = v.addr[31:2];
      mData[mIdx(v.addr)]  = v.inst;
   endtask

   task automatic applyStimulus(vec_t v);
      int idx;
      tick();
      idx = mIdx(v.addr);
      if (mValid[idx] && (mTag[idx] == v.addr[31:2])) begin
         cpuCe   = 1'b1;
         cpuAddr = v.addr;
         expQ.push_back(mData[idx]);
         @(negedge clk);
         checkOutput("hit_nostall", {30'd0, busReq, stallreq}, 32'd0);
         popCompare("hit_inst");
      end else begin
         doMiss(v);
      end
   endtask

   task automatic probeMiss(string name, logic [31:0] a);
      tick();
      cpuCe   = 1'b1;
      cpuAddr = a;
      @(negedge clk);
      checkOutput(name, {stallreq, cpuInst[30:0]}, 32'h8000_0000);
      #1 cpuCe = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0000, 32'h2000_0001, 0, 0};
      vecs[1]  = '{32'h0000_0100, 32'h3402_0020, 2, 3};
      vecs[2]  = '{32'h0000_0100, 32'h3402_0020, 0, 0};
      vecs[3]  = '{32'h0000_0103, 32'h3402_0020, 0, 0};
      vecs[4]  = '{32'h0000_0004, 32'h2000_0002, 1, TO - 1};
      vecs[5]  = '{32'h0000_0000, 32'h2000_0001, 0, 1};
      vecs[6]  = '{32'h0000_0008, 32'h2000_0003, 0, 1};
      vecs[7]  = '{32'h0000_000C, 32'h2000_0004, 0, 1};
      vecs[8]  = '{32'h0000_0010, 32'h2000_0005, 0, 1};
      vecs[9]  = '{32'h0000_0004, 32'h2000_0002, 0, 1};
      vecs[10] = '{32'h0000_0000, 32'h2000_0001, 0, 1};
      mInvalidate();

      rst       = 1'b0;
      cpuCe     = 1'b1;
      cpuAddr   = '0;
      flush     = 1'b0;
      busGnt    = 1'b0;
      busRvalid = 1'b0;
      busRdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_inst", cpuInst, 32'd0);
      checkOutput("reset_ctrl", {28'd0, stallreq, err, busReq, 1'b0}, 32'd0);
      checkOutput("reset_busaddr", busAddr, 32'd0);
      tick();
      rst   = 1'b1;
      cpuCe = 1'b0;

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

      // Bus timeout: grant, then silence until the abort
      tick();
      cpuCe   = 1'b1;
      cpuAddr = 32'h0000_0300;
      tick();
      busGnt = 1'b1;
      tick();
      busGnt = 1'b0;
      @(negedge clk);
      checkOutput("to_wait0_noerr", 32'(err), 32'd0);
      for (int k = 1; k <= TO; k++) begin
         tick();
         @(negedge clk);
         checkOutput("to_err_pulse", 32'(err), (k == TO) ? 32'd1 : 32'd0);
         if (k == TO) begin
            expQ.push_back(32'h0000_0000);
            checkOutput("to_stall_released", 32'(stallreq), 32'd0);
            popCompare("to_nop");
         end
      end
      tick();
      @(negedge clk);
      checkOutput("to_err_one_cycle", 32'(err), 32'd0);
      checkOutput("to_no_fill", 32'(stallreq), 32'd1);
      #1 cpuCe = 1'b0;
      #1 checkOutput("ce_off_quiet", {stallreq, cpuInst[30:0]}, 32'd0);

      // Flush while the fetch is outstanding: returned data must be dropped
      tick();
      cpuCe   = 1'b1;
      cpuAddr = 32'h0000_0200;
      tick();
      busGnt = 1'b1;
      tick();
      busGnt = 1'b0;
      flush  = 1'b1;
      mInvalidate();
      tick();
      flush     = 1'b0;
      busRvalid = 1'b1;
      busRdata  = 32'hDEAD_BEEF;
      tick();
      busRvalid = 1'b0;
      busRdata  = '0;
      @(negedge clk);
      checkOutput("flush_dropped", {stallreq, cpuInst[30:0]}, 32'h8000_0000);
      tick();
      @(negedge clk);
      checkOutput("flush_refetch_addr", busAddr, 32'h0000_0200);
      checkOutput("flush_refetch_req", 32'(busReq), 32'd1);
      busGnt = 1'b1;
      tick();
      busGnt    = 1'b0;
      busRvalid = 1'b1;
      busRdata  = 32'h1111_2222;
      expQ.push_back(32'h1111_2222);
      tick();
      busRvalid = 1'b0;
      busRdata  = '0;
      @(negedge clk);
      popCompare("flush_refill_inst");
      mValid[mIdx(32'h200)] = 1'b1;
      mTag[mIdx(32'h200)]   = 30'h80;
      mData[mIdx(32'h200)]  = 32'h1111_2222;
      applyStimulus('{32'h0000_0200, 32'h1111_2222, 0, 0});
      tick();
      cpuCe = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      mInvalidate();
      probeMiss("flushall_200", 32'h0000_0200);
      probeMiss("flushall_010", 32'h0000_0010);
      probeMiss("flushall_00c", 32'h0000_000C);

      // Asynchronous reset in the middle of WAIT, then a stray late response
      tick();
      cpuCe   = 1'b1;
      cpuAddr = 32'h0000_0400;
      tick();
      busGnt = 1'b1;
      tick();
      busGnt = 1'b0;
      #2 rst = 1'b0;
      #1 checkOutput("arst_outputs", {29'd0, stallreq, err, busReq}, 32'd0);
      cpuCe = 1'b0;
      mInvalidate();
      #2 rst = 1'b1;
      tick();
      busRvalid = 1'b1;
      busRdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      checkOutput("arst_idle_noreq", 32'(busReq), 32'd0);
      tick();
      busRvalid = 1'b0;
      busRdata  = '0;
      probeMiss("arst_no_fill", 32'h0000_0400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
